// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the 8-bit stack-machine CPU: opcodes, ALU
// function codes, control-FSM state encoding and the control strobe bundle.
package stack_cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int ALUOP_W = 2;

    // Instruction opcodes carried in IR[7:5]
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
    localparam logic [OPC_W-1:0] OP_NOT  = 3'b011;
    localparam logic [OPC_W-1:0] OP_PUSH = 3'b100;
    localparam logic [OPC_W-1:0] OP_POP  = 3'b101;
    localparam logic [OPC_W-1:0] OP_JMP  = 3'b110;
    localparam logic [OPC_W-1:0] OP_JZ   = 3'b111;

    // ALU function select; arithmetic/logic opcodes map onto these via OPC[1:0]
    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

    // Control FSM states, one per machine cycle
    typedef enum logic [3:0] {
        ST_IF   = 4'd0,
        ST_ID   = 4'd1,
        ST_POPA = 4'd2,
        ST_POPB = 4'd3,
        ST_EXE  = 4'd4,
        ST_WB   = 4'd5,
        ST_MRD  = 4'd6,
        ST_PSH  = 4'd7,
        ST_POPS = 4'd8,
        ST_MWR  = 4'd9,
        ST_JMP  = 4'd10,
        ST_JZ   = 4'd11
    } state_t;

    // All datapath control strobes for one cycle
    typedef struct packed {
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               src_a;
        logic               src_b;
        logic               ld_a;
        logic               ld_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               pc_write;
        logic               pc_src;
        logic               tos;
        logic               push;
        logic               pop;
        logic               pc_write_cond;
        logic               mtos;
        logic               instr_done;
    } ctrl_t;

endpackage

// File: rtl/stack_mc_ctrl_dec.sv
// Moore output decoder: maps the current control state onto the datapath
// strobes. Anything not listed for a state stays 0.
module stack_mc_ctrl_dec
    import stack_cpu_pkg::*;
(
    input  state_t             state,
    input  logic [ALUOP_W-1:0] alu_fn,
    output ctrl_t              ctrl
);

    // Decode state into strobes; start from all-zero so each state only names what it drives
    always_comb begin
        ctrl = '0;
        unique case (state)
            ST_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.src_a    = 1'b1;
                ctrl.src_b    = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.pc_write = 1'b1;
            end
            ST_ID: begin
                ctrl.tos = 1'b1;
            end
            ST_POPA, ST_POPS: begin
                ctrl.tos  = 1'b1;
                ctrl.ld_a = 1'b1;
                ctrl.pop  = 1'b1;
            end
            ST_POPB: begin
                ctrl.tos  = 1'b1;
                ctrl.ld_b = 1'b1;
                ctrl.pop  = 1'b1;
            end
            ST_EXE: begin
                ctrl.alu_op = alu_fn;
            end
            ST_WB: begin
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_PSH: begin
                ctrl.mtos       = 1'b1;
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JMP: begin
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JZ: begin
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/stack_mc_ctrl.sv
// Multicycle control unit for the stack-machine datapath. Holds the state
// register and next-state logic; outputs come from the Moore decoder.
module stack_mc_ctrl
    import stack_cpu_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   OPC,
    output logic               IorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               IRWrite,
    output logic               SrcA,
    output logic               SrcB,
    output logic               LdA,
    output logic               LdB,
    output logic [ALUOP_W-1:0] AluOP,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               tos,
    output logic               Push,
    output logic               Pop,
    output logic               PCWriteCond,
    output logic               MtoS,
    output logic               instr_done,
    output logic [3:0]         dbg_state
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    logic [2:0] opc;

    // Opcode decode only ever needs the architectural 3 bits
    assign opc = 3'(OPC);

    // State register; async reset parks the FSM in instruction fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; OPC is only consulted in ID and POPA where IR is stable
    always_comb begin
        state_nxt = ST_IF;
        unique case (state)
            ST_IF: state_nxt = ST_ID;
            ST_ID: begin
                unique case (opc)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: state_nxt = ST_POPA;
                    OP_PUSH:                        state_nxt = ST_MRD;
                    OP_POP:                         state_nxt = ST_POPS;
                    OP_JMP:                         state_nxt = ST_JMP;
                    OP_JZ:                          state_nxt = ST_JZ;
                    default:                        state_nxt = ST_IF;
                endcase
            end
            // NOT is unary: only one operand pop before execute
            ST_POPA: state_nxt = (opc == OP_NOT) ? ST_EXE : ST_POPB;
            ST_POPB: state_nxt = ST_EXE;
            ST_EXE:  state_nxt = ST_WB;
            ST_MRD:  state_nxt = ST_PSH;
            ST_POPS: state_nxt = ST_MWR;
            ST_WB, ST_PSH, ST_MWR, ST_JMP, ST_JZ: state_nxt = ST_IF;
            default: state_nxt = ST_IF;
        endcase
    end

    stack_mc_ctrl_dec u_dec (
        .state  (state),
        .alu_fn (opc[1:0]),
        .ctrl   (ctrl)
    );

    assign IorD        = ctrl.iord;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign SrcA        = ctrl.src_a;
    assign SrcB        = ctrl.src_b;
    assign LdA         = ctrl.ld_a;
    assign LdB         = ctrl.ld_b;
    assign AluOP       = ALUOP_W'(ctrl.alu_op);
    assign PCWrite     = ctrl.pc_write;
    assign PCSrc       = ctrl.pc_src;
    assign tos         = ctrl.tos;
    assign Push        = ctrl.push;
    assign Pop         = ctrl.pop;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign MtoS        = ctrl.mtos;
    assign instr_done  = ctrl.instr_done;
    assign dbg_state   = state;

endmodule

// File: tb/tb_stack_mc_ctrl.sv
// Bench for stack_mc_ctrl: per-cycle strobe model built from each opcode's
// cycle table, directed opcode walk, async reset mid-instruction, and a
// random opcode run with mutual-exclusion checks on every cycle.
module tb_stack_mc_ctrl;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       src_a;
    logic       src_b;
    logic       ld_a;
    logic       ld_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_src;
    logic       tos;
    logic       push;
    logic       pop;
    logic       pc_write_cond;
    logic       mtos;
    logic       done;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] opc_in = 3'b000;
  always #5 clk = ~clk;

  logic       iord, mem_read, mem_write, ir_write, src_a, src_b, ld_a, ld_b;
  logic [1:0] alu_op;
  logic       pc_write, pc_src, tos_o, push, pop, pc_write_cond, mtos, instr_done;
  logic [3:0] dbg_state;

  stack_mc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .OPC         (opc_in),
    .IorD        (iord),
    .memRead     (mem_read),
    .memWrite    (mem_write),
    .IRWrite     (ir_write),
    .SrcA        (src_a),
    .SrcB        (src_b),
    .LdA         (ld_a),
    .LdB         (ld_b),
    .AluOP       (alu_op),
    .PCWrite     (pc_write),
    .PCSrc       (pc_src),
    .tos         (tos_o),
    .Push        (push),
    .Pop         (pop),
    .PCWriteCond (pc_write_cond),
    .MtoS        (mtos),
    .instr_done  (instr_done),
    .dbg_state   (dbg_state)
  );

  vec_t got;
  assign got = {iord, mem_read, mem_write, ir_write, src_a, src_b, ld_a, ld_b, alu_op,
                pc_write, pc_src, tos_o, push, pop, pc_write_cond, mtos, instr_done};

  int checks = 0;
  int errors = 0;
  vec_t exp_vec = '0;
  logic exp_valid = 1'b0;
  logic [18:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // model: instruction length in cycles, from the opcode table
  function automatic int instr_len(input logic [2:0] o);
    case (o)
      3'd0, 3'd1, 3'd2: return 6;
      3'd3:             return 5;
      3'd4, 3'd5:       return 4;
      default:          return 3;
    endcase
  endfunction

  // model: strobes expected in cycle k (0 = fetch) of an instruction with opcode o
  function automatic vec_t model_out(input logic [2:0] o, input int k);
    vec_t v;
    int   n;
    v = '0;
    n = instr_len(o);
    if (k == 0) begin
      v.mem_read = 1'b1; v.ir_write = 1'b1; v.src_a = 1'b1; v.src_b = 1'b1; v.pc_write = 1'b1;
    end else if (k == 1) begin
      v.tos = 1'b1;
    end else if (o < 3'd4) begin
      if (k == 2) begin
        v.tos = 1'b1; v.ld_a = 1'b1; v.pop = 1'b1;
      end else if (k == 3 && o != 3'd3) begin
        v.tos = 1'b1; v.ld_b = 1'b1; v.pop = 1'b1;
      end else if (k == n - 2) begin
        v.alu_op = o[1:0];
      end else begin
        v.push = 1'b1; v.done = 1'b1;
      end
    end else if (o == 3'd4) begin
      if (k == 2) begin v.iord = 1'b1; v.mem_read = 1'b1; end
      else begin v.mtos = 1'b1; v.push = 1'b1; v.done = 1'b1; end
    end else if (o == 3'd5) begin
      if (k == 2) begin v.tos = 1'b1; v.ld_a = 1'b1; v.pop = 1'b1; end
      else begin v.iord = 1'b1; v.mem_write = 1'b1; v.done = 1'b1; end
    end else if (o == 3'd6) begin
      v.pc_src = 1'b1; v.pc_write = 1'b1; v.done = 1'b1;
    end else begin
      v.pc_src = 1'b1; v.pc_write_cond = 1'b1; v.done = 1'b1;
    end
    return v;
  endfunction

  // scoreboard: every meaningful cycle compares against the model, plus exclusion rules
  always @(negedge clk) begin
    if (exp_valid) begin
      exp_q.push_back(exp_vec);
      check("cycle_vec", 32'(got), 32'(exp_q.pop_front()));
    end
    check("excl_push_pop", 32'(push & pop), 32'd0);
    check("excl_rd_wr", 32'(mem_read & mem_write), 32'd0);
    check("excl_pcw_pcwc", 32'(pc_write & pc_write_cond), 32'd0);
  end

  // driver: run one instruction from IF; report cycles to instr_done and observations
  task automatic run_instr(input logic [2:0] o, output int cycles, output logic saw_ldb,
                           output logic [1:0] alu_or, output vec_t done_vec);
    opc_in   = o;
    cycles   = 0;
    saw_ldb  = 1'b0;
    alu_or   = 2'b00;
    done_vec = '0;
    for (int k = 0; k < instr_len(o); k++) begin
      exp_vec   = model_out(o, k);
      exp_valid = 1'b1;
      @(negedge clk);
      saw_ldb = saw_ldb | ld_b;
      alu_or  = alu_or | alu_op;
      if (instr_done && cycles == 0) begin
        cycles   = k + 1;
        done_vec = got;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int         cyc;
  logic       sldb;
  logic [1:0] aor;
  vec_t       dv;
  logic [2:0] ro;

  initial begin
    // reset held 3 cycles with OPC=000
    rst       = 1'b1;
    exp_vec   = model_out(3'd0, 0);
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_memread", 32'(mem_read), 32'd1);
    check("rst_irwrite", 32'(ir_write), 32'd1);
    check("rst_pcwrite", 32'(pc_write), 32'd1);
    check("rst_srca_srcb", 32'({src_a, src_b}), 32'd3);
    check("rst_aluop", 32'(alu_op), 32'd0);
    check("rst_others", 32'({iord, mem_write, ld_a, ld_b, pc_src, tos_o, push, pop,
                             pc_write_cond, mtos, instr_done}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(3'd0, cyc, sldb, aor, dv);
    check("add_cycles", 32'(cyc), 32'd6);
    check("add_aluop", 32'(aor), 32'd0);
    check("add_wb_push", 32'(dv.push), 32'd1);
    run_instr(3'd1, cyc, sldb, aor, dv);
    check("sub_cycles", 32'(cyc), 32'd6);
    check("sub_aluop", 32'(aor), 32'd1);
    run_instr(3'd3, cyc, sldb, aor, dv);
    check("not_cycles", 32'(cyc), 32'd5);
    check("not_aluop", 32'(aor), 32'd3);
    check("not_no_ldb", 32'(sldb), 32'd0);
    run_instr(3'd2, cyc, sldb, aor, dv);
    check("and_cycles", 32'(cyc), 32'd6);
    check("and_aluop", 32'(aor), 32'd2);
    run_instr(3'd4, cyc, sldb, aor, dv);
    check("push_cycles", 32'(cyc), 32'd4);
    check("push_mtos", 32'({dv.mtos, dv.push}), 32'd3);
    run_instr(3'd5, cyc, sldb, aor, dv);
    check("pop_cycles", 32'(cyc), 32'd4);
    check("pop_mwr", 32'({dv.iord, dv.mem_write}), 32'd3);
    run_instr(3'd6, cyc, sldb, aor, dv);
    check("jmp_cycles", 32'(cyc), 32'd3);
    check("jmp_pc", 32'({dv.pc_src, dv.pc_write, dv.pc_write_cond}), 32'b110);
    run_instr(3'd7, cyc, sldb, aor, dv);
    check("jz_cycles", 32'(cyc), 32'd3);
    check("jz_pc", 32'({dv.pc_src, dv.pc_write, dv.pc_write_cond}), 32'b101);
    check("jz_no_pop", 32'(dv.pop), 32'd0);

    // ADD interrupted by async reset in EXE
    opc_in = 3'd0;
    for (int k = 0; k < 4; k++) begin
      exp_vec   = model_out(3'd0, k);
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
    #1 check("exe_before_rst", 32'(got), 32'(model_out(3'd0, 4)));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_if_decode", 32'(got), 32'(model_out(3'd0, 0)));
    exp_vec   = model_out(3'd0, 0);
    exp_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(3'd0, cyc, sldb, aor, dv);
    check("add_after_rst_cycles", 32'(cyc), 32'd6);

    // random opcode stream
    for (int i = 0; i < 1000; i++) begin
      ro = 3'($urandom_range(0, 7));
      run_instr(ro, cyc, sldb, aor, dv);
      check("rand_cycles", 32'(cyc), 32'(instr_len(ro)));
    end

    exp_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_mc_ctrl.md
Name: stack_mc_ctrl

Overview:
- Multicycle control unit for the 8-bit stack-machine datapath.
- Consumes the 3-bit opcode (IR[7:5]) returned by the datapath.
- Drives every datapath control strobe from a Moore FSM, one state per cycle.
- Sits beside the datapath in the CPU top level; the two blocks together form the processor.

Parameters:
- OPC_W, 3, opcode width.
- ALUOP_W, 2, ALU function select width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- OPC  in  OPC_W  opcode from IR[7:5].
- IorD  out  1  memory address select: 0 = PC, 1 = IR[4:0].
- memRead  out  1  memory read enable.
- memWrite  out  1  memory write enable (write data = A).
- IRWrite  out  1  IR load.
- SrcA  out  1  ALU A select: 0 = A register, 1 = zero-extended PC.
- SrcB  out  1  ALU B select: 0 = B register, 1 = constant 1.
- LdA  out  1  A register load from stack top.
- LdB  out  1  B register load from stack top.
- AluOP  out  ALUOP_W  ALU function: 00 add, 01 sub, 10 and, 11 not(A).
- PCWrite  out  1  unconditional PC load.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = IR[4:0].
- tos  out  1  stack top-of-stack read enable.
- Push  out  1  stack push of the MtoS-selected value.
- Pop  out  1  stack pop.
- PCWriteCond  out  1  PC load qualified by Z==0.
- MtoS  out  1  stack input select: 0 = AluOut, 1 = MDR.
- instr_done  out  1  high in the last state of each instruction.

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ. All 8 codes are legal.
- Outputs are a pure Moore decode of the state register. Any strobe not listed for a state is 0.
- rst asserted (async) forces state to IF; rst deasserted leaves the FSM in IF at the first edge.
- During reset the outputs show the IF decode; datapath registers are held by their own reset.
- States, asserted outputs, and next state:
  - IF: memRead, IorD=0, IRWrite, SrcA=1, SrcB=1, AluOP=00, PCSrc=0, PCWrite. Next: ID.
  - ID: tos (Z captures stack top). Next by OPC: ADD/SUB/AND/NOT -> POPA; PUSH -> MRD; POP -> POPS; JMP -> JMP; JZ -> JZ.
  - POPA: tos, LdA, Pop. Next: POPB for ADD/SUB/AND; EXE for NOT.
  - POPB: tos, LdB, Pop. Next: EXE.
  - EXE: SrcA=0, SrcB=0, AluOP = OPC[1:0]. Next: WB.
  - WB: MtoS=0, Push, instr_done. Next: IF.
  - MRD: IorD=1, memRead (MDR captures the word). Next: PSH.
  - PSH: MtoS=1, Push, instr_done. Next: IF.
  - POPS: tos, LdA, Pop. Next: MWR.
  - MWR: IorD=1, memWrite, instr_done. Next: IF.
  - JMP: PCSrc=1, PCWrite, instr_done. Next: IF.
  - JZ: PCSrc=1, PCWriteCond, instr_done. Next: IF. JZ does not pop.
- Cycles per instruction: ADD/SUB/AND 6; NOT 5; PUSH 4; POP 4; JMP 3; JZ 3.
- OPC is sampled only in ID and POPA. IR changes only in IF, so OPC is stable in those states.
- Mutual exclusion at all times: never Push & Pop together; never memRead & memWrite together; never PCWrite & PCWriteCond together.
- rst mid-instruction returns the FSM to IF immediately; partial stack/memory effects already committed are not undone.

Decomposition:
- Shared package stack_cpu_pkg holds:
  - opcode constants OP_ADD..OP_JZ;
  - ALU constants ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT;
  - state enum (IF, ID, POPA, POPB, EXE, WB, MRD, PSH, POPS, MWR, JMP, JZ) in 4-bit encoding.
- One natural sub-module: stack_mc_ctrl_dec, a combinational state->outputs decoder. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles, OPC=000 -> state IF. Outputs: memRead=1, IRWrite=1, PCWrite=1, SrcA=1, SrcB=1, AluOP=00, all others 0.
- ADD: OPC=000 after reset release -> sequence IF, ID, POPA, POPB, EXE(AluOP=00), WB(Push=1, instr_done=1), IF. 6 cycles.
- SUB then NOT: OPC=001 -> EXE shows AluOP=01 over 6 cycles. Then OPC=011 -> IF, ID, POPA, EXE(AluOP=11), WB. 5 cycles, LdB never asserted.
- PUSH then POP: OPC=100 -> MRD(IorD=1, memRead=1), PSH(MtoS=1, Push=1). Then OPC=101 -> POPS(LdA=1, Pop=1), MWR(IorD=1, memWrite=1). 4 cycles each.
- JMP and JZ: OPC=110 -> JMP state with PCSrc=1, PCWrite=1. OPC=111 -> JZ state with PCSrc=1, PCWriteCond=1, PCWrite=0. 3 cycles each.
- Reset in EXE of ADD: assert rst asynchronously mid-cycle -> outputs switch to the IF decode before the next edge. Run random opcodes 1000 instructions, checking the mutual-exclusion assertions every cycle.
